// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE constants, mode encodings and absorb-path state type.
package keccak_pkg;

  localparam int w             = 64;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;

  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b10;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b11;

  // SHAKE domain-separation byte and the final pad bit in the last rate byte.
  localparam logic [7:0] PAD_SHAKE_DS = 8'h1F;
  localparam logic [7:0] PAD_FINAL    = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    HOLD = 2'd2
  } absorb_state_t;

  // Words per rate block for a mode; unknown encodings fall back to SHAKE128.
  function automatic int words_per_block(input logic [1:0] mode, input int width);
    return (mode == SHAKE256_MODE_VEC) ? (RATE_SHAKE256 / width) : (RATE_SHAKE128 / width);
  endfunction

endpackage

// File: rtl/sipo_buffer.sv
// Serial-in/parallel-out word buffer: byte-masked indexed write, two
// independent OR ports for padding bytes, synchronous clear.
module sipo_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 21,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH/8-1:0]       wr_be,
  input  logic                     or_a_en,
  input  logic [IDX_W-1:0]         or_a_idx,
  input  logic [WIDTH-1:0]         or_a_data,
  input  logic                     or_b_en,
  input  logic [IDX_W-1:0]         or_b_idx,
  input  logic [WIDTH-1:0]         or_b_data,
  output logic [WIDTH*DEPTH-1:0]   data_out
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [WIDTH-1:0] word_d;
      logic [WIDTH-1:0] word_q;

      // Next word value: clear wins, otherwise masked write then both OR ports
      // (the OR ports may hit the same word, e.g. 0x1F and 0x80 together).
      always_comb begin
        word_d = word_q;
        if (clr) begin
          word_d = '0;
        end else begin
          if (wr_en && (wr_idx == IDX_W'(gi))) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
              if (wr_be[b]) word_d[8*b +: 8] = wr_data[8*b +: 8];
            end
          end
          if (or_a_en && (or_a_idx == IDX_W'(gi))) word_d = word_d | or_a_data;
          if (or_b_en && (or_b_idx == IDX_W'(gi))) word_d = word_d | or_b_data;
        end
      end

      // Word storage register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) word_q <= '0;
        else      word_q <= word_d;
      end

      assign data_out[WIDTH*gi +: WIDTH] = word_q;
    end
  endgenerate

endmodule

// File: rtl/absorb_datapath.sv
// Absorb-side input path: gathers message words into a rate block, applies
// SHAKE padding (0x1F ... 0x80) and hands full blocks to the permutation.
module absorb_datapath
  import keccak_pkg::*;
#(
  parameter int W        = w,
  parameter int RATE_MAX = RATE_SHAKE128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          operation_mode,
  input  logic [W-1:0]        data_in,
  input  logic                data_in_valid,
  input  logic                data_in_last,
  input  logic [3:0]          data_in_bytes,
  output logic                data_in_ready,
  output logic [RATE_MAX-1:0] block_out,
  output logic                block_valid,
  output logic                block_last,
  input  logic                block_ready
);

  localparam int DEPTH  = RATE_MAX / W;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int NBYTES = W / 8;

  absorb_state_t    state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic             pad_pending_q, pad_pending_d;
  logic             block_last_q, block_last_d;
  logic [1:0]       mode_q, mode_d;
  logic             in_msg_q, in_msg_d;
  logic             run_q, run_d;

  logic [1:0]       eff_mode;
  logic [IDX_W-1:0] last_idx;
  logic             accept;

  logic             buf_clr;
  logic             wr_en;
  logic [W-1:0]     wr_data;
  logic [NBYTES-1:0] wr_be;
  logic             or_a_en;
  logic             or_b_en;
  logic [W-1:0]     tail_word;
  logic [NBYTES-1:0] tail_be;

  // Mode is taken live for the first word of a message, then held.
  assign eff_mode = in_msg_q ? mode_q : operation_mode;
  assign last_idx = IDX_W'(words_per_block(eff_mode, W) - 1);

  // run_q keeps ready low until the first edge after reset release.
  assign data_in_ready = run_q && (state_q == FILL);
  assign accept        = data_in_valid && data_in_ready;
  assign block_valid   = (state_q == HOLD);
  assign block_last    = block_last_q;

  // Partial final word: bytes below b pass through, byte b becomes 0x1F.
  // Bytes above b are left unwritten; they are still zero from the last clear.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_tail
      assign tail_word[8*gi +: 8] = (data_in_bytes == 4'(gi)) ? PAD_SHAKE_DS : data_in[8*gi +: 8];
      assign tail_be[gi]          = (data_in_bytes >= 4'(gi));
    end
  endgenerate

  // Next-state, word index and buffer-control decode for FILL/PAD/HOLD.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    pad_pending_d = pad_pending_q;
    block_last_d  = block_last_q;
    mode_d        = mode_q;
    in_msg_d      = in_msg_q;
    run_d         = 1'b1;
    buf_clr       = 1'b0;
    wr_en         = 1'b0;
    wr_data       = data_in;
    wr_be         = '1;
    or_a_en       = 1'b0;
    or_b_en       = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          wr_en    = 1'b1;
          in_msg_d = 1'b1;
          mode_d   = eff_mode;
          if (data_in_last && (data_in_bytes < 4'(NBYTES))) begin
            wr_data = tail_word;
            wr_be   = tail_be;
            state_d = PAD;
          end else begin
            // A full final word defers the 0x1F byte to the next word slot,
            // which may sit in a fresh block if this word fills the current one.
            if (data_in_last) pad_pending_d = 1'b1;
            if (k_q == last_idx) begin
              state_d      = HOLD;
              block_last_d = 1'b0;
            end else begin
              k_d = k_q + 1'b1;
              if (data_in_last) state_d = PAD;
            end
          end
        end
      end

      PAD: begin
        if (pad_pending_q) begin
          or_a_en       = 1'b1;
          pad_pending_d = 1'b0;
        end
        or_b_en      = 1'b1;
        block_last_d = 1'b1;
        state_d      = HOLD;
      end

      HOLD: begin
        if (block_ready) begin
          buf_clr      = 1'b1;
          k_d          = '0;
          block_last_d = 1'b0;
          if (block_last_q) in_msg_d = 1'b0;
          state_d = pad_pending_q ? PAD : FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FILL;
      k_q           <= '0;
      pad_pending_q <= 1'b0;
      block_last_q  <= 1'b0;
      mode_q        <= SHAKE128_MODE_VEC;
      in_msg_q      <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      pad_pending_q <= pad_pending_d;
      block_last_q  <= block_last_d;
      mode_q        <= mode_d;
      in_msg_q      <= in_msg_d;
      run_q         <= run_d;
    end
  end

  sipo_buffer #(
    .WIDTH (W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (buf_clr),
    .wr_en     (wr_en),
    .wr_idx    (k_q),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .or_a_en   (or_a_en),
    .or_a_idx  (k_q),
    .or_a_data ({{(W-8){1'b0}}, PAD_SHAKE_DS}),
    .or_b_en   (or_b_en),
    .or_b_idx  (last_idx),
    .or_b_data ({PAD_FINAL, {(W-8){1'b0}}}),
    .data_out  (block_out)
  );

endmodule

// File: doc/absorb_datapath.md
# absorb_datapath

Input-side counterpart of the squeeze/dump path: collects `w`-bit message words from an external valid/ready stream into a rate-wide serial-in/parallel-out buffer, applies SHAKE multi-rate padding (0x1F … 0x80), and hands complete rate blocks to the Keccak permutation stage over a valid/ready handshake. It sits between the external data input and the absorb/XOR stage of the core.

## Interface
- `W`, default `w` (64), word width in bits
- `RATE_MAX`, default `RATE_SHAKE128` (1344), buffer width in bits; `RATE_MAX/W` = 21 words
---
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-low reset (asserted at 0)
- `operation_mode` in 2: `SHAKE128_MODE_VEC` → 21 words/block; `SHAKE256_MODE_VEC` → 17; other → 21
- `data_in` in W: message word; byte k at bits [8k+7:8k]
- `data_in_valid` in 1: word offered
- `data_in_last` in 1: final word of message
- `data_in_bytes` in 4: valid bytes in final word, 0..8 (ignored unless last)
- `data_in_ready` out 1: word accepted when valid && ready
- `block_out` out RATE_MAX: assembled block; word i at bits [W*i+W-1:W*i]
- `block_valid` out 1: block complete
- `block_last` out 1: block is final (padded) block of message
- `block_ready` in 1: consumer takes block when valid && ready

## Operation
- States: FILL, PAD, HOLD. Reset → FILL, word index k=0, buffer zero, `pad_pending`=0.
- Mode sampled on the first accepted word of a message (k=0, no message in progress); held until `block_last` handshake.
- FILL: `data_in_ready`=1. Accepted word written to word k.
  - last=0: if k==max-1 → HOLD (`block_last`=0), else k+1.
  - last=1, bytes b<8: bytes ≥ b zeroed, byte b = 0x1F; → PAD.
  - last=1, b==8: full word stored, `pad_pending`=1; if k==max-1 → HOLD (`block_last`=0), else k+1 then → PAD.
- PAD (one cycle, `data_in_ready`=0): if `pad_pending`, byte 0 of word k |= 0x1F, clear `pad_pending`; byte 7 of word max-1 |= 0x80 (0x9F when coinciding with 0x1F); → HOLD, `block_last`=1.
- HOLD: `block_valid`=1, `data_in_ready`=0, buffer frozen. On `block_ready`: buffer cleared, k=0; → PAD if `pad_pending`, else FILL.
- SHAKE256: words 17..20 of `block_out` are always zero.
- b=0 with last: byte 0 of word k = 0x1F (empty message / aligned tail).

## Timing
- Reset values: `data_in_ready`=0 while `rst`=0, 1 from first edge after release; `block_valid`=0, `block_last`=0, `block_out`=0.
- Non-final block: `block_valid` rises the cycle after the max-th word is accepted.
- Final block: last word accepted at cycle N → PAD at N+1 → `block_valid` at N+2.
- Overflow padding block (b=8 filling block): first block handshake at cycle M → PAD M+1 → padding-only block valid M+2.
- `block_valid`, `block_out`, `block_last` stable until handshake; `block_ready` while not valid is ignored.
- Throughput: 1 word/cycle in FILL; no input accepted during PAD/HOLD (no double buffering).
- `rst` asserted mid-message: immediate return to reset values, partial block discarded.

## Structure
- `keccak_pkg`: `w`, `RATE_SHAKE128`, `RATE_SHAKE256`, mode vectors, new constants `PAD_SHAKE_DS` (8'h1F), `PAD_FINAL` (8'h80), and `absorb_state_t` enum {FILL, PAD, HOLD}.
- Sub-module `sipo_buffer` (WIDTH, DEPTH): indexed word write with byte mask, byte-OR port, synchronous clear, async reset; FSM, counter and padding logic in `absorb_datapath`.

## Test plan
- SHAKE128, 21 full words (last=0) then last word b=3 value 0x0000_0000_00CC_BBAA → block 1 = 21 words; block 2 word 0 = 0x0000_0000_1FCC_BBAA, word 20 = 0x8000_0000_0000_0000, `block_last`=1.
- SHAKE256, empty message (last, b=0) → word 0 = 0x1F, word 16 = 0x80<<56, words 17..20 zero, valid 2 cycles after accept.
- SHAKE256, 17 words with 17th last b=8 → block 1 unpadded `block_last`=0; after handshake padding-only block, word 0=0x1F, word 16=0x80<<56.
- SHAKE128, 20 words + last b=7 → byte 7 of word 20 = 0x9F.
- `block_ready` held low 10 cycles then high; `data_in_valid` toggling → no word lost/duplicated, ready=0 throughout HOLD.
- `rst` low mid-fill at word 5 → all outputs zero; next message starts at word 0 with fresh mode.
